coherency_watch_issuer: RTL and testbench
=========================================

COHERENCY_WATCH_ISSUER -- requirements
Module: coherency_watch_issuer

Interface
REQ-001 SHALL have parameter CacheLineNum, default 4, max addresses per watch batch (matches coherency controller).
REQ-002 SHALL have parameter BackoffWidth, default 16, backoff counter width.
REQ-003 SHALL have parameter AddrWidth, default width of dcp_pkg::paddr_t, physical address width.
REQ-004 SHALL have port clk_i  in  1  clock; single clock domain.
REQ-005 SHALL have port rst_ni  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports cfg_valid_i in 1 / cfg_ready_o out 1, batch configuration handshake.
REQ-007 SHALL have port cfg_base_i  in  AddrWidth  first cache-line address of batch.
REQ-008 SHALL have port cfg_size_i  in  $clog2(CacheLineNum)+1  number of lines to watch.
REQ-009 SHALL have port cfg_backoff_i  in  BackoffWidth  backoff cycles between notify and re-arm.
REQ-010 SHALL have port disable_i  in  1  stop watching, return to IDLE.
REQ-011 SHALL have ports watch_valid_o out 1 / watch_ready_i in 1, watch_addr_o out AddrWidth, watch_last_o out 1: one address per beat toward the coherency controller.
REQ-012 SHALL have ports notify_valid_i in 1 / notify_ready_o out 1: controller reports a watched line changed.
REQ-013 SHALL have port rearm_o  out  1  one-cycle pulse when a batch is (re)issued completely.

Function
REQ-014 SHALL implement states IDLE, ISSUE, WAIT, BACKOFF.
REQ-015 SHALL assert cfg_ready_o only in IDLE; on cfg handshake latch base, size (clamped to CacheLineNum), backoff.
REQ-016 SHALL stay in IDLE when latched size is 0; otherwise go to ISSUE next cycle.
REQ-017 SHALL in ISSUE drive watch_addr_o = base + 64*idx (idx 0..size-1), wrapping modulo 2^AddrWidth; watch_last_o high when idx = size-1.
REQ-018 SHALL hold watch_valid_o, addr, last stable until watch_ready_i; idx increments only on handshake.
REQ-019 SHALL on last-beat handshake pulse rearm_o for one cycle and enter WAIT.
REQ-020 SHALL assert notify_ready_o only in WAIT; notify handshake loads backoff counter and enters BACKOFF.
REQ-021 SHALL in BACKOFF decrement counter each cycle; at 0 re-enter ISSUE with idx=0; backoff 0 yields ISSUE the cycle after notify.
REQ-022 SHALL on disable_i in WAIT or BACKOFF go to IDLE next cycle; in ISSUE finish the pending beat handshake (valid never withdrawn) then go to IDLE without rearm_o; disable_i in IDLE blocks cfg_ready_o.
REQ-023 SHALL ignore notify_valid_i outside WAIT (no state change, notify_ready_o low).

Reset
REQ-024 SHALL on rst_ni low asynchronously enter IDLE; cfg_ready_o=1 (if disable_i low), watch_valid_o=0, watch_addr_o=0, watch_last_o=0, notify_ready_o=0, rearm_o=0, counters 0.
REQ-025 SHALL drop watch_valid_o immediately on reset mid-ISSUE; partial batch discarded.

Configuration
REQ-026 SHALL with COHORT_WATCH_EXP_BACKOFF_EN defined double the loaded backoff on each consecutive notify (saturating at all-ones), resetting to cfg_backoff_i on new cfg; without it, backoff is always cfg_backoff_i.

Verification
REQ-027 SHALL cover: cfg base=0x1000,size=3,backoff=5 -> beats 0x1000,0x1040,0x1080(last), rearm_o pulse; notify -> 5 idle cycles -> same 3 beats again.
REQ-028 SHALL cover: watch_ready_i low 4 cycles on beat 1 -> addr 0x1040 held stable, valid high throughout.
REQ-029 SHALL cover: size=7 with CacheLineNum=4 -> exactly 4 beats; size=0 -> no beats, cfg_ready_o stays 1.
REQ-030 SHALL cover: base=all-ones minus 0x3F, size=2 -> second beat addr 0x0 (wrap).
REQ-031 SHALL cover: disable_i during BACKOFF -> IDLE next cycle, no further beats; rst_ni low mid-ISSUE -> watch_valid_o 0 same cycle.
REQ-032 SHALL cover: COHORT_WATCH_EXP_BACKOFF_EN, backoff=3, three notifies -> gaps 3, 6, 12 cycles; undefined -> 3, 3, 3.

Source files
------------

// File: rtl/coherency_watch_issuer.sv
// Issues batches of cache-line watch addresses and re-arms them after notify + backoff.
// Optional COHORT_WATCH_EXP_BACKOFF_EN: backoff doubles on each consecutive notify.
package dcp_pkg;
  typedef logic [63:0] paddr_t;
endpackage

module coherency_watch_issuer #(
  parameter int CacheLineNum = 4,
  parameter int BackoffWidth = 16,
  parameter int AddrWidth    = $bits(dcp_pkg::paddr_t),
  localparam int SizeWidth   = $clog2(CacheLineNum) + 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    cfg_valid_i,
  output logic                    cfg_ready_o,
  input  logic [AddrWidth-1:0]    cfg_base_i,
  input  logic [SizeWidth-1:0]    cfg_size_i,
  input  logic [BackoffWidth-1:0] cfg_backoff_i,
  input  logic                    disable_i,
  output logic                    watch_valid_o,
  input  logic                    watch_ready_i,
  output logic [AddrWidth-1:0]    watch_addr_o,
  output logic                    watch_last_o,
  input  logic                    notify_valid_i,
  output logic                    notify_ready_o,
  output logic                    rearm_o
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    BACKOFF
  } state_e;

  state_e                  state_q, state_d;
  logic [AddrWidth-1:0]    base_q, base_d;
  logic [SizeWidth-1:0]    size_q, size_d;
  logic [SizeWidth-1:0]    idx_q, idx_d;
  logic [BackoffWidth-1:0] bo_q, bo_d;
  logic [BackoffWidth-1:0] cnt_q, cnt_d;
  logic                    rearm_q, rearm_d;
  logic                    dis_pend_q, dis_pend_d;

  logic [SizeWidth-1:0]    size_clamp;
  logic [AddrWidth-1:0]    beat_addr;
  logic                    is_last;

  assign size_clamp = (cfg_size_i > SizeWidth'(CacheLineNum))
                    ? SizeWidth'(CacheLineNum) : cfg_size_i;
  assign beat_addr  = base_q + (AddrWidth'(idx_q) << 6);
  assign is_last    = (idx_q == size_q - SizeWidth'(1));

  assign cfg_ready_o    = (state_q == IDLE) && !disable_i;
  assign notify_ready_o = (state_q == WAIT) && !disable_i;
  assign watch_valid_o  = (state_q == ISSUE);
  assign watch_addr_o   = watch_valid_o ? beat_addr : '0;
  assign watch_last_o   = watch_valid_o && is_last;
  assign rearm_o        = rearm_q;

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    size_d     = size_q;
    idx_d      = idx_q;
    bo_d       = bo_q;
    cnt_d      = cnt_q;
    rearm_d    = 1'b0;
    dis_pend_d = dis_pend_q;
    case (state_q)
      IDLE: begin
        dis_pend_d = 1'b0;
        if (cfg_valid_i && cfg_ready_o) begin
          base_d = cfg_base_i;
          size_d = size_clamp;
          bo_d   = cfg_backoff_i;
          idx_d  = '0;
          if (size_clamp != '0) state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (disable_i) dis_pend_d = 1'b1;
        if (watch_ready_i) begin
          // a disable seen mid-batch aborts once the shown beat is taken
          if (dis_pend_q || disable_i) begin
            state_d    = IDLE;
            idx_d      = '0;
            dis_pend_d = 1'b0;
          end else if (is_last) begin
            state_d = WAIT;
            idx_d   = '0;
            rearm_d = 1'b1;
          end else begin
            idx_d = idx_q + SizeWidth'(1);
          end
        end
      end
      WAIT: begin
        if (disable_i) begin
          state_d = IDLE;
        end else if (notify_valid_i) begin
`ifdef COHORT_WATCH_EXP_BACKOFF_EN
          bo_d = bo_q[BackoffWidth-1] ? '1 : {bo_q[BackoffWidth-2:0], 1'b0};
`endif
          idx_d = '0;
          if (bo_q == '0) begin
            state_d = ISSUE;
          end else begin
            cnt_d   = bo_q;
            state_d = BACKOFF;
          end
        end
      end
      BACKOFF: begin
        if (disable_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - BackoffWidth'(1);
          if (cnt_q == BackoffWidth'(1)) begin
            state_d = ISSUE;
            idx_d   = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      base_q     <= '0;
      size_q     <= '0;
      idx_q      <= '0;
      bo_q       <= '0;
      cnt_q      <= '0;
      rearm_q    <= 1'b0;
      dis_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      size_q     <= size_d;
      idx_q      <= idx_d;
      bo_q       <= bo_d;
      cnt_q      <= cnt_d;
      rearm_q    <= rearm_d;
      dis_pend_q <= dis_pend_d;
    end
  end

endmodule

// File: tb/tb_coherency_watch_issuer.sv
// Directed bench for coherency_watch_issuer.
// Gap expectations follow COHORT_WATCH_EXP_BACKOFF_EN.
module tb_coherency_watch_issuer;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [63:0] cfg_base;
  logic [2:0]  cfg_size;
  logic [15:0] cfg_backoff;
  logic        dis;
  logic        watch_valid;
  logic        watch_ready;
  logic [63:0] watch_addr;
  logic        watch_last;
  logic        notify_valid;
  logic        notify_ready;
  logic        rearm;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  coherency_watch_issuer dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .cfg_valid_i   (cfg_valid),
    .cfg_ready_o   (cfg_ready),
    .cfg_base_i    (cfg_base),
    .cfg_size_i    (cfg_size),
    .cfg_backoff_i (cfg_backoff),
    .disable_i     (dis),
    .watch_valid_o (watch_valid),
    .watch_ready_i (watch_ready),
    .watch_addr_o  (watch_addr),
    .watch_last_o  (watch_last),
    .notify_valid_i(notify_valid),
    .notify_ready_o(notify_ready),
    .rearm_o       (rearm)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [63:0] b, input logic [2:0] s,
                     input logic [15:0] bo);
    cfg_base    = b;
    cfg_size    = s;
    cfg_backoff = bo;
    cfg_valid   = 1'b1;
    step();
    cfg_valid   = 1'b0;
  endtask

  task automatic run_beats(input string tag, input logic [63:0] b,
                           input int n);
    for (int i = 0; i < n; i++) begin
      chk({tag, "_valid"}, 64'(watch_valid), 64'd1);
      chk({tag, "_addr"}, watch_addr, b + 64'(i) * 64'd64);
      chk({tag, "_last"}, 64'(watch_last), 64'(i == n - 1));
      step();
    end
    chk({tag, "_rearm"}, 64'(rearm), 64'd1);
    chk({tag, "_nrdy"}, 64'(notify_ready), 64'd1);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!watch_valid && n < 100) begin
      step();
      n++;
    end
  endtask

  task automatic go_idle(input string tag);
    dis = 1'b1;
    step();
    chk({tag, "_blocked"}, 64'(cfg_ready), 64'd0);
    dis = 1'b0;
    #1;
    chk({tag, "_idle"}, 64'(cfg_ready), 64'd1);
  endtask

`ifdef COHORT_WATCH_EXP_BACKOFF_EN
  int exp_gap [3] = '{3, 6, 12};
`else
  int exp_gap [3] = '{3, 3, 3};
`endif

  initial begin
    int n;
    logic seen;
    rst_ni       = 1'b1;
    cfg_valid    = 1'b0;
    cfg_base     = '0;
    cfg_size     = '0;
    cfg_backoff  = '0;
    dis          = 1'b0;
    watch_ready  = 1'b0;
    notify_valid = 1'b0;
    #2 rst_ni = 1'b0;
    #1;
    chk("rst_cfg_ready", 64'(cfg_ready), 64'd1);
    chk("rst_valid", 64'(watch_valid), 64'd0);
    chk("rst_addr", watch_addr, 64'd0);
    chk("rst_last", 64'(watch_last), 64'd0);
    chk("rst_nrdy", 64'(notify_ready), 64'd0);
    chk("rst_rearm", 64'(rearm), 64'd0);
    #10 rst_ni = 1'b1;
    step();

    // basic batch, notify, backoff 5, re-issue
    watch_ready = 1'b1;
    cfg(64'h1000, 3'd3, 16'd5);
    chk("b1_cfg_ready", 64'(cfg_ready), 64'd0);
    run_beats("b1", 64'h1000, 3);
    step();
    chk("b1_rearm_pulse", 64'(rearm), 64'd0);
    notify_valid = 1'b1;
    step();
    notify_valid = 1'b0;
    wait_valid(n);
    chk("b1_gap", 64'(n), 64'd5);
    run_beats("b1r", 64'h1000, 3);
    go_idle("b1");

    // stall on beat 1, notify ignored outside WAIT
    cfg(64'h1000, 3'd3, 16'd5);
    step();
    watch_ready  = 1'b0;
    notify_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("st_valid", 64'(watch_valid), 64'd1);
      chk("st_addr", watch_addr, 64'h1040);
      chk("st_nrdy", 64'(notify_ready), 64'd0);
      step();
    end
    notify_valid = 1'b0;
    watch_ready  = 1'b1;
    #1;
    chk("st_addr_rel", watch_addr, 64'h1040);
    step();
    chk("st_beat2", watch_addr, 64'h1080);
    step();
    chk("st_rearm", 64'(rearm), 64'd1);
    go_idle("st");

    // clamp 7 -> 4 beats
    cfg(64'h2000, 3'd7, 16'd1);
    run_beats("cl", 64'h2000, 4);
    go_idle("cl");

    // size 0 issues nothing
    cfg(64'h2000, 3'd0, 16'd1);
    chk("z_cfg_ready", 64'(cfg_ready), 64'd1);
    chk("z_valid", 64'(watch_valid), 64'd0);
    step();
    chk("z_valid2", 64'(watch_valid), 64'd0);

    // address wrap
    cfg(64'hFFFF_FFFF_FFFF_FFC0, 3'd2, 16'd4);
    chk("wr_addr0", watch_addr, 64'hFFFF_FFFF_FFFF_FFC0);
    step();
    chk("wr_addr1", watch_addr, 64'h0);
    chk("wr_last", 64'(watch_last), 64'd1);
    step();
    chk("wr_rearm", 64'(rearm), 64'd1);

    // disable during backoff
    notify_valid = 1'b1;
    step();
    notify_valid = 1'b0;
    step();
    dis = 1'b1;
    step();
    chk("db_cfg_blocked", 64'(cfg_ready), 64'd0);
    chk("db_valid", 64'(watch_valid), 64'd0);
    chk("db_nrdy", 64'(notify_ready), 64'd0);
    dis  = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      step();
      if (watch_valid) seen = 1'b1;
    end
    chk("db_nobeat", 64'(seen), 64'd0);
    chk("db_idle", 64'(cfg_ready), 64'd1);

    // disable in ISSUE: beat completes, no rearm
    watch_ready = 1'b0;
    cfg(64'h5000, 3'd3, 16'd2);
    dis = 1'b1;
    step();
    dis = 1'b0;
    chk("di_valid_held", 64'(watch_valid), 64'd1);
    chk("di_addr_held", watch_addr, 64'h5000);
    watch_ready = 1'b1;
    step();
    chk("di_valid_off", 64'(watch_valid), 64'd0);
    chk("di_no_rearm", 64'(rearm), 64'd0);
    chk("di_idle", 64'(cfg_ready), 64'd1);

    // reset mid-ISSUE
    watch_ready = 1'b0;
    cfg(64'h3000, 3'd3, 16'd2);
    chk("rm_valid_pre", 64'(watch_valid), 64'd1);
    rst_ni = 1'b0;
    #1;
    chk("rm_valid", 64'(watch_valid), 64'd0);
    chk("rm_addr", watch_addr, 64'd0);
    chk("rm_cfg_ready", 64'(cfg_ready), 64'd1);
    #10 rst_ni = 1'b1;
    step();
    chk("rm_idle_valid", 64'(watch_valid), 64'd0);

    // consecutive notifies, backoff 3
    watch_ready = 1'b1;
    cfg(64'h4000, 3'd1, 16'd3);
    chk("g_last", 64'(watch_last), 64'd1);
    step();
    chk("g_rearm", 64'(rearm), 64'd1);
    for (int k = 0; k < 3; k++) begin
      notify_valid = 1'b1;
      step();
      notify_valid = 1'b0;
      wait_valid(n);
      chk("g_gap", 64'(n), 64'(exp_gap[k]));
      chk("g_addr", watch_addr, 64'h4000);
      step();
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
